mdio_phy_responder: RTL and testbench

// PHY-side end of the MDIO management interface: the serial responder that answers

---
 rtl/mdio_phy_responder.sv | 192 +++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_responder.sv
// PHY-side MDIO responder: decodes master frames and serves a small register file.
// Writes update the register file. Reads shift register data back on MDIO_OUT/MDIO_OE.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR  = 5'b00010,
  parameter int         REG_COUNT = 8
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic        WR_STB,
  output logic [4:0]  WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        ERR
);

  localparam int         AW      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [5:0] REG_LIM = 6'(REG_COUNT);

  typedef enum logic [2:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, WDATA, RDATA} state_t;

  state_t      state, state_n;
  logic [1:0]  mdc_sync, mdio_sync;
  logic        mdc_prev, mdc_rise, bit_in;
  logic [4:0]  cnt, cnt_n;
  logic        armed, armed_n, is_wr, is_wr_n, match, match_n, first, first_n;
  logic [3:0]  addr_sr, addr_sr_n;
  logic [4:0]  addr_full, regad, regad_n;
  logic [15:0] shift, shift_n;
  logic        out_n, oe_n, err_n, wr_en;
  logic [15:0] regs [REG_COUNT];

  assign mdc_rise  = mdc_sync[1] & ~mdc_prev;
  assign bit_in    = mdio_sync[1];
  assign addr_full = {addr_sr, bit_in};

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      mdc_sync  <= '0;
      mdio_sync <= '1;
      mdc_prev  <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      is_wr     <= 1'b0;
      match     <= 1'b0;
      first     <= 1'b0;
      addr_sr   <= '0;
      regad     <= '0;
      shift     <= '0;
      MDIO_OUT  <= 1'b1;
      MDIO_OE   <= 1'b0;
      WR_STB    <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      ERR       <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      mdc_sync  <= {mdc_sync[0], MDC};
      mdio_sync <= {mdio_sync[0], MDIO_IN};
      mdc_prev  <= mdc_sync[1];
      state     <= state_n;
      cnt       <= cnt_n;
      armed     <= armed_n;
      is_wr     <= is_wr_n;
      match     <= match_n;
      first     <= first_n;
      addr_sr   <= addr_sr_n;
      regad     <= regad_n;
      shift     <= shift_n;
      MDIO_OUT  <= out_n;
      MDIO_OE   <= oe_n;
      WR_STB    <= wr_en;
      ERR       <= err_n;
      if (wr_en) begin
        regs[regad[AW-1:0]] <= shift_n;
        WR_ADDR             <= regad;
        WR_DATA             <= shift_n;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    armed_n   = armed;
    is_wr_n   = is_wr;
    match_n   = match;
    first_n   = first;
    addr_sr_n = addr_sr;
    regad_n   = regad;
    shift_n   = shift;
    out_n     = MDIO_OUT;
    oe_n      = MDIO_OE;
    err_n     = 1'b0;
    wr_en     = 1'b0;
    if (mdc_rise) begin
      cnt_n = cnt + 5'd1;
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (bit_in)     armed_n = 1'b1;
          else if (armed) state_n = ST1;
        end
        ST1: begin
          cnt_n = '0;
          if (bit_in) state_n = OP;
          else begin
            err_n   = 1'b1;
            armed_n = 1'b0;
            state_n = IDLE;
          end
        end
        OP: begin
          first_n = bit_in;
          if (cnt == 5'd1) begin
            cnt_n = '0;
            if (first == bit_in) begin
              err_n   = 1'b1;
              armed_n = 1'b0;
              state_n = IDLE;
            end else begin
              is_wr_n = ~first;
              state_n = PHYAD;
            end
          end
        end
        PHYAD: begin
          addr_sr_n = addr_full[3:0];
          if (cnt == 5'd4) begin
            cnt_n   = '0;
            match_n = (addr_full == PHY_ADDR);
            state_n = REGAD;
          end
        end
        REGAD: begin
          addr_sr_n = addr_full[3:0];
          if (cnt == 5'd4) begin
            cnt_n   = '0;
            regad_n = addr_full;
            state_n = TA;
            if (!is_wr && match)
              shift_n = ({1'b0, addr_full} < REG_LIM) ? regs[addr_full[AW-1:0]] : 16'h0000;
          end
        end
        TA: begin
          first_n = bit_in;
          if (cnt == 5'd1) begin
            cnt_n = '0;
            if (is_wr) begin
              if ({first, bit_in} != 2'b10) begin
                err_n   = 1'b1;
                armed_n = 1'b0;
                state_n = IDLE;
              end else state_n = WDATA;
            end else begin
              // read turnaround: take the line on the second TA edge, driving 0
              if (match) begin
                oe_n  = 1'b1;
                out_n = 1'b0;
              end
              state_n = RDATA;
            end
          end
        end
        WDATA: begin
          shift_n = {shift[14:0], bit_in};
          if (cnt == 5'd15) begin
            wr_en   = match && ({1'b0, regad} < REG_LIM);
            armed_n = 1'b0;
            state_n = IDLE;
          end
        end
        RDATA: begin
          if (cnt == 5'd16) begin
            oe_n    = 1'b0;
            out_n   = 1'b1;
            armed_n = 1'b0;
            state_n = IDLE;
          end else if (match) begin
            out_n   = shift[15];
            shift_n = {shift[14:0], 1'b0};
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Randomized self-checking bench for mdio_phy_responder against a register-file model.
module tb_mdio_phy_responder;
  localparam logic [4:0] MY = 5'b00010;

  logic        clk = 1'b0;
  logic        RESET, MDC, MDIO_IN, MDIO_OUT, MDIO_OE, WR_STB, ERR;
  logic [4:0]  WR_ADDR;
  logic [15:0] WR_DATA;

  int total = 0, bad = 0;
  int stb_seen = 0, err_seen = 0;
  logic [15:0] ref_regs [32];
  logic [41:0] s_oe, s_out;

  always #5 clk = ~clk;

  mdio_phy_responder #(.PHY_ADDR(MY), .REG_COUNT(8)) dut (
    .clk(clk), .RESET(RESET), .MDC(MDC), .MDIO_IN(MDIO_IN),
    .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .WR_STB(WR_STB),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .ERR(ERR)
  );

  always @(posedge clk) begin
    if (WR_STB) stb_seen++;
    if (ERR)    err_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  // What the master sees, sampled just before each of its MDC rising edges:
  // a read hands the line over with a 0, then data MSB first, 17 periods total.
  function automatic logic [41:0] exp_oe(input logic rd);
    logic [41:0] v;
    v = '0;
    if (rd) v[40:24] = '1;
    return v;
  endfunction

  function automatic logic [41:0] exp_out(input logic rd, input logic [15:0] d);
    logic [41:0] v;
    v = '1;
    if (rd) begin
      v[24] = 1'b0;
      for (int j = 0; j < 16; j++) v[25+j] = d[15-j];
    end
    return v;
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] ra);
    return (ra < 5'd8) ? ref_regs[ra] : 16'h0000;
  endfunction

  task automatic mdc_bit(input logic b, output logic o, output logic oe);
    MDIO_IN = b;
    MDC = 1'b0;
    repeat (4) @(negedge clk);
    o  = MDIO_OUT;
    oe = MDIO_OE;
    MDC = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // 8 preamble ones, then len frame bits, then ones up to 42 MDC periods
  task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [1:0] ta, input logic [15:0] d, input int len);
    logic [31:0] bits;
    logic b, o, e;
    bits = {2'b01, op, phy, ra, ta, d};
    for (int i = 0; i < 42; i++) begin
      if (i < 8) b = 1'b1;
      else if (i - 8 < len) b = bits[31-(i-8)];
      else b = 1'b1;
      mdc_bit(b, o, e);
      s_out[i] = o;
      s_oe[i]  = e;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; MDC = 1'b0; MDIO_IN = 1'b1;
    for (int i = 0; i < 32; i++) ref_regs[i] = 16'h0000;
    repeat (3) @(negedge clk);
    total++;
    if ({MDIO_OUT, MDIO_OE, WR_STB, ERR} !== 4'b1000) begin
      bad++; $display("FAIL reset_ctl: got %b want 1000", {MDIO_OUT, MDIO_OE, WR_STB, ERR});
    end
    total++;
    if ({WR_ADDR, WR_DATA} !== 21'h0) begin
      bad++; $display("FAIL reset_wr: got %h want 0", {WR_ADDR, WR_DATA});
    end
    RESET = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_read();
    int s0, e0;
    s0 = stb_seen; e0 = err_seen;
    frame(2'b01, MY, 5'd4, 2'b10, 16'h2140, 32);
    ref_regs[4] = 16'h2140;
    total++;
    if (stb_seen - s0 !== 1 || err_seen - e0 !== 0) begin
      bad++; $display("FAIL wr_pulses: got stb=%0d err=%0d want 1 0", stb_seen - s0, err_seen - e0);
    end
    total++;
    if (WR_ADDR !== 5'd4 || WR_DATA !== 16'h2140) begin
      bad++; $display("FAIL wr_fields: got %h/%h want 04/2140", WR_ADDR, WR_DATA);
    end
    total++;
    if (s_oe !== exp_oe(1'b0)) begin
      bad++; $display("FAIL wr_oe: got %h want %h", s_oe, exp_oe(1'b0));
    end
    frame(2'b10, MY, 5'd4, 2'b11, 16'hFFFF, 32);
    total++;
    if (s_oe !== exp_oe(1'b1)) begin
      bad++; $display("FAIL rd_oe: got %h want %h", s_oe, exp_oe(1'b1));
    end
    total++;
    if (s_out !== exp_out(1'b1, model_read(5'd4))) begin
      bad++; $display("FAIL rd_out: got %h want %h", s_out, exp_out(1'b1, model_read(5'd4)));
    end
  endtask

  task automatic test_no_match();
    int s0;
    s0 = stb_seen;
    frame(2'b01, 5'b00011, 5'd4, 2'b10, 16'hFFFF, 32);
    total++;
    if (stb_seen - s0 !== 0 || s_oe !== exp_oe(1'b0)) begin
      bad++; $display("FAIL nm_write: got stb=%0d oe=%h want 0 0", stb_seen - s0, s_oe);
    end
    frame(2'b10, 5'b00011, 5'd4, 2'b11, 16'hFFFF, 32);
    total++;
    if (s_oe !== exp_oe(1'b0) || s_out !== exp_out(1'b0, 16'h0)) begin
      bad++; $display("FAIL nm_read: got oe=%h out=%h want 0 all-ones", s_oe, s_out);
    end
    frame(2'b10, MY, 5'd4, 2'b11, 16'hFFFF, 32);
    total++;
    if (s_out !== exp_out(1'b1, model_read(5'd4))) begin
      bad++; $display("FAIL nm_reg4: got %h want %h", s_out, exp_out(1'b1, model_read(5'd4)));
    end
  endtask

  task automatic test_bad_op();
    int s0, e0;
    s0 = stb_seen; e0 = err_seen;
    frame(2'b00, MY, 5'd1, 2'b10, 16'h1234, 4);
    total++;
    if (err_seen - e0 !== 1 || stb_seen - s0 !== 0) begin
      bad++; $display("FAIL op00: got err=%0d stb=%0d want 1 0", err_seen - e0, stb_seen - s0);
    end
    s0 = stb_seen; e0 = err_seen;
    frame(2'b01, MY, 5'd1, 2'b10, 16'hBEEF, 32);
    ref_regs[1] = 16'hBEEF;
    total++;
    if (stb_seen - s0 !== 1 || WR_ADDR !== 5'd1 || WR_DATA !== 16'hBEEF || err_seen - e0 !== 0) begin
      bad++; $display("FAIL after_op00: got stb=%0d %h/%h want 1 01/beef", stb_seen - s0, WR_ADDR, WR_DATA);
    end
    e0 = err_seen;
    frame(2'b11, MY, 5'd1, 2'b10, 16'h1234, 4);
    total++;
    if (err_seen - e0 !== 1) begin
      bad++; $display("FAIL op11: got err=%0d want 1", err_seen - e0);
    end
  endtask

  task automatic test_bad_ta();
    int s0, e0;
    s0 = stb_seen; e0 = err_seen;
    frame(2'b01, MY, 5'd2, 2'b11, 16'h5555, 16);
    total++;
    if (err_seen - e0 !== 1 || stb_seen - s0 !== 0) begin
      bad++; $display("FAIL ta11: got err=%0d stb=%0d want 1 0", err_seen - e0, stb_seen - s0);
    end
    frame(2'b10, MY, 5'd20, 2'b11, 16'hFFFF, 32);
    total++;
    if (s_oe !== exp_oe(1'b1) || s_out !== exp_out(1'b1, 16'h0000)) begin
      bad++; $display("FAIL rd_oor: got %h/%h want %h/%h", s_oe, s_out, exp_oe(1'b1), exp_out(1'b1, 16'h0));
    end
    s0 = stb_seen;
    frame(2'b01, MY, 5'd20, 2'b10, 16'hAAAA, 32);
    total++;
    if (stb_seen - s0 !== 0) begin
      bad++; $display("FAIL wr_oor: got stb=%0d want 0", stb_seen - s0);
    end
  endtask

  task automatic test_random();
    logic wr;
    logic [4:0] phy, ra;
    logic [15:0] d;
    logic exp_stb, rd_match;
    int s0;
    for (int n = 0; n < 36; n++) begin
      wr  = 1'($urandom_range(0, 1));
      phy = ($urandom_range(0, 4) == 0) ? 5'($urandom) : MY;
      ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
      d   = 16'($urandom);
      s0  = stb_seen;
      frame(wr ? 2'b01 : 2'b10, phy, ra, wr ? 2'b10 : 2'b11, wr ? d : 16'hFFFF, 32);
      exp_stb  = wr && phy == MY && ra < 5'd8;
      rd_match = !wr && phy == MY;
      if (exp_stb) ref_regs[ra] = d;
      total++;
      if (stb_seen - s0 !== int'(exp_stb)) begin
        bad++; $display("FAIL rnd_stb[%0d]: got %0d want %0d", n, stb_seen - s0, exp_stb);
      end
      total++;
      if (s_oe !== exp_oe(rd_match) || s_out !== exp_out(rd_match, model_read(ra))) begin
        bad++; $display("FAIL rnd_line[%0d]: got %h/%h want %h/%h", n, s_oe, s_out,
                        exp_oe(rd_match), exp_out(rd_match, model_read(ra)));
      end
      if (exp_stb) begin
        total++;
        if (WR_ADDR !== ra || WR_DATA !== d) begin
          bad++; $display("FAIL rnd_wr[%0d]: got %h/%h want %h/%h", n, WR_ADDR, WR_DATA, ra, d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    for (int r = 0; r < 8; r += 3) begin
      d = 16'($urandom);
      frame(2'b01, MY, 5'(r), 2'b10, d, 32);
      ref_regs[r] = d;
      frame(2'b10, MY, 5'(r), 2'b11, 16'hFFFF, 32);
      total++;
      if (s_out !== exp_out(1'b1, d)) begin
        bad++; $display("FAIL b2b[%0d]: got %h want %h", r, s_out, exp_out(1'b1, d));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits;
    logic b, o, e;
    frame(2'b01, MY, 5'd4, 2'b10, 16'h2140, 32);
    bits = {2'b01, 2'b10, MY, 5'd4, 2'b11, 16'hFFFF};
    for (int i = 0; i < 33; i++) begin
      b = (i < 8) ? 1'b1 : bits[31-(i-8)];
      mdc_bit(b, o, e);
    end
    total++;
    if (MDIO_OE !== 1'b1) begin
      bad++; $display("FAIL mid_oe_pre: got %b want 1", MDIO_OE);
    end
    #2 RESET = 1'b1;
    #1;
    total++;
    if (MDIO_OE !== 1'b0 || MDIO_OUT !== 1'b1) begin
      bad++; $display("FAIL mid_reset: got oe=%b out=%b want 0 1", MDIO_OE, MDIO_OUT);
    end
    MDC = 1'b0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 16'h0000;
    repeat (3) @(negedge clk);
    frame(2'b10, MY, 5'd4, 2'b11, 16'hFFFF, 32);
    total++;
    if (s_oe !== exp_oe(1'b1) || s_out !== exp_out(1'b1, model_read(5'd4))) begin
      bad++; $display("FAIL post_reset_rd: got %h/%h want %h/%h", s_oe, s_out,
                      exp_oe(1'b1), exp_out(1'b1, model_read(5'd4)));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_no_match();
    test_bad_op();
    test_bad_ta();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
